output_link_tx: RTL and testbench

- Transmit end of a router-to-router link: the upstream counterpart that feeds a downstream router's per-VC input buffers.
- Sits after the crossbar on each output port. Registers outgoing flits onto the link.
- Tracks per-downstream-VC ownership (FREE/RESERVED/ACTIVE/WAIT_RELEASE) for the VC allocator and gates the switch allocator with downstream on/off flow control.
- Flags protocol violations on a one-cycle error pulse.

---
 rtl/output_link_tx.sv | 164 ++++++++++++++++
 tb/tb_output_link_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/output_link_tx.sv
// rtl/output_link_tx.sv - router output link transmitter with per-VC ownership tracking and flow control

package noc_params;
   localparam int VC_NUM  = 2;
   localparam int VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam int DATA_W  = 16;

   typedef enum logic [1:0] {
      HEAD     = 2'd0,
      BODY     = 2'd1,
      TAIL     = 2'd2,
      HEADTAIL = 2'd3
   } flit_label_t;

   typedef struct packed {
      flit_label_t          flit_label;
      logic [VC_SIZE-1:0]   vc_id;
      logic [DATA_W-1:0]    data;
   } flit_t;
endpackage

module output_link_tx
   import noc_params::*;
#(
   parameter int VC_NUM = noc_params::VC_NUM
) (
   input  logic                      clk,
   input  logic                      rst,
   input  flit_t                     flit_i,
   input  logic                      valid_i,
   input  logic                      va_grant_i,
   input  logic [VC_SIZE-1:0]        va_grant_vc_i,
   input  logic [VC_NUM-1:0]         on_off_i,
   input  logic [VC_NUM-1:0]         vc_release_i,
   output flit_t                     flit_o,
   output logic                      valid_o,
   output logic [VC_NUM-1:0]         vc_available_o,
   output logic [VC_NUM-1:0]         send_ok_o,
   output logic                      err_o
);

   typedef enum logic [1:0] {
      FREE         = 2'd0,
      RESERVED     = 2'd1,
      ACTIVE       = 2'd2,
      WAIT_RELEASE = 2'd3
   } vc_state_t;

   vc_state_t state_q [VC_NUM];
   vc_state_t state_d [VC_NUM];

   logic grant_vc_ok;
   logic flit_vc_ok;
   logic accept;
   logic err_d;

   // VC indices only need a range check when VC_NUM is not a power of two
   if (VC_NUM == (1 << VC_SIZE)) begin : g_full_range
      assign grant_vc_ok = 1'b1;
      assign flit_vc_ok  = 1'b1;
   end else begin : g_part_range
      assign grant_vc_ok = ({1'b0, va_grant_vc_i} < (VC_SIZE+1)'(VC_NUM));
      assign flit_vc_ok  = ({1'b0, flit_i.vc_id} < (VC_SIZE+1)'(VC_NUM));
   end

   // Allocator-facing status comes straight from registered state; send_ok also follows on_off
   always_comb begin
      for (int v = 0; v < VC_NUM; v++) begin
         vc_available_o[v] = (state_q[v] == FREE);
         send_ok_o[v]      = on_off_i[v] & ((state_q[v] == RESERVED) | (state_q[v] == ACTIVE));
      end
   end

   // Flit acceptance, per-VC next state and error collection, all against current registered state
   always_comb begin
      vc_state_t cur_state;
      logic      label_ok;

      accept    = 1'b0;
      err_d     = 1'b0;
      cur_state = FREE;
      label_ok  = 1'b0;
      for (int v = 0; v < VC_NUM; v++) begin
         state_d[v] = state_q[v];
      end

      if (valid_i) begin
         if (flit_vc_ok) begin
            cur_state = state_q[flit_i.vc_id];
            case (cur_state)
               RESERVED: label_ok = (flit_i.flit_label == HEAD) || (flit_i.flit_label == HEADTAIL);
               ACTIVE:   label_ok = (flit_i.flit_label == BODY) || (flit_i.flit_label == TAIL);
               default:  label_ok = 1'b0;
            endcase
            accept = label_ok & on_off_i[flit_i.vc_id];
         end
         if (!accept) begin
            err_d = 1'b1;
         end
      end

      if (va_grant_i) begin
         if (!grant_vc_ok) begin
            err_d = 1'b1;
         end else if (state_q[va_grant_vc_i] != FREE) begin
            err_d = 1'b1;
         end
      end

      for (int v = 0; v < VC_NUM; v++) begin
         if (vc_release_i[v] && (state_q[v] != WAIT_RELEASE)) begin
            err_d = 1'b1;
         end
         case (state_q[v])
            FREE: begin
               if (va_grant_i && grant_vc_ok && (va_grant_vc_i == VC_SIZE'(v))) begin
                  state_d[v] = RESERVED;
               end
            end
            RESERVED: begin
               if (accept && (flit_i.vc_id == VC_SIZE'(v))) begin
                  state_d[v] = (flit_i.flit_label == HEADTAIL) ? WAIT_RELEASE : ACTIVE;
               end
            end
            ACTIVE: begin
               if (accept && (flit_i.vc_id == VC_SIZE'(v)) && (flit_i.flit_label == TAIL)) begin
                  state_d[v] = WAIT_RELEASE;
               end
            end
            WAIT_RELEASE: begin
               if (vc_release_i[v]) begin
                  state_d[v] = FREE;
               end
            end
            default: begin
               state_d[v] = FREE;
               err_d      = 1'b1;
            end
         endcase
      end
   end

   // State, link register and error pulse; reset clears everything asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int v = 0; v < VC_NUM; v++) begin
            state_q[v] <= FREE;
         end
         flit_o  <= '0;
         valid_o <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         for (int v = 0; v < VC_NUM; v++) begin
            state_q[v] <= state_d[v];
         end
         valid_o <= accept;
         err_o   <= err_d;
         if (accept) begin
            flit_o <= flit_i;
         end
      end
   end

endmodule

// File: tb/tb_output_link_tx.sv
// tb/tb_output_link_tx.sv - vector-table and scoreboard bench for output_link_tx
module tb_output_link_tx;
   import noc_params::*;

   logic                clk = 1'b0;
   logic                rst;
   flit_t               flit_i;
   logic                valid_i;
   logic                va_grant_i;
   logic [VC_SIZE-1:0]  va_grant_vc_i;
   logic [VC_NUM-1:0]   on_off_i;
   logic [VC_NUM-1:0]   vc_release_i;
   flit_t               flit_o;
   logic                valid_o;
   logic [VC_NUM-1:0]   vc_available_o;
   logic [VC_NUM-1:0]   send_ok_o;
   logic                err_o;

   output_link_tx #(.VC_NUM(VC_NUM)) dut (
      .clk            (clk),
      .rst            (rst),
      .flit_i         (flit_i),
      .valid_i        (valid_i),
      .va_grant_i     (va_grant_i),
      .va_grant_vc_i  (va_grant_vc_i),
      .on_off_i       (on_off_i),
      .vc_release_i   (vc_release_i),
      .flit_o         (flit_o),
      .valid_o        (valid_o),
      .vc_available_o (vc_available_o),
      .send_ok_o      (send_ok_o),
      .err_o          (err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic                v;
      flit_label_t         lb;
      logic [VC_SIZE-1:0]  vc;
      logic                g;
      logic [VC_SIZE-1:0]  gvc;
      logic [VC_NUM-1:0]   oo;
      logic [VC_NUM-1:0]   rel;
      logic                ev;
      logic                ee;
      logic [VC_NUM-1:0]   eav;
      logic [VC_NUM-1:0]   esok;
   } vec_t;

   typedef struct {
      logic                ev;
      logic                ee;
      logic [VC_NUM-1:0]   eav;
      flit_t               ef;
   } exp_t;

   vec_t  tbl[$];
   exp_t  sb[$];
   int    total = 0;
   int    bad   = 0;
   flit_t last_flit = '0;

   function automatic vec_t mk(input logic v, input flit_label_t lb, input logic [VC_SIZE-1:0] vc,
                               input logic g, input logic [VC_SIZE-1:0] gvc, input logic [VC_NUM-1:0] oo,
                               input logic [VC_NUM-1:0] rel, input logic ev, input logic ee,
                               input logic [VC_NUM-1:0] eav, input logic [VC_NUM-1:0] esok);
      vec_t r;
      r.v = v; r.lb = lb; r.vc = vc; r.g = g; r.gvc = gvc; r.oo = oo; r.rel = rel;
      r.ev = ev; r.ee = ee; r.eav = eav; r.esok = esok;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      valid_i       = 1'b0;
      flit_i        = '0;
      va_grant_i    = 1'b0;
      va_grant_vc_i = '0;
      on_off_i      = '1;
      vc_release_i  = '0;
   endtask

   initial begin
      vec_t  t;
      exp_t  e;
      flit_t f;

      rst = 1'b1;
      idle_inputs();
      #12;
      check("reset valid_o", 32'(valid_o), 32'd0);
      check("reset err_o", 32'(err_o), 32'd0);
      check("reset flit_o", 32'(flit_o), 32'd0);
      check("reset vc_available_o", 32'(vc_available_o), 32'b11);
      check("reset send_ok_o", 32'(send_ok_o), 32'b00);
      @(negedge clk);
      rst = 1'b0;

      //           v     lb        vc    g     gvc   oo     rel    ev    ee    eav    esok
      // basic packet on VC1
      tbl.push_back(mk(1'b0, HEAD,     1'b0, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00));
      tbl.push_back(mk(1'b1, HEAD,     1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 2'b10));
      tbl.push_back(mk(1'b1, BODY,     1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 2'b10));
      tbl.push_back(mk(1'b1, TAIL,     1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 2'b10));
      tbl.push_back(mk(1'b0, HEAD,     1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00));
      tbl.push_back(mk(1'b0, HEAD,     1'b0, 1'b0, 1'b0, 2'b11, 2'b10, 1'b0, 1'b0, 2'b11, 2'b00));
      // single-flit packet on VC0
      tbl.push_back(mk(1'b0, HEAD,     1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00));
      tbl.push_back(mk(1'b1, HEADTAIL, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 2'b01));
      tbl.push_back(mk(1'b0, HEAD,     1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00));
      tbl.push_back(mk(1'b0, HEAD,     1'b0, 1'b0, 1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 2'b11, 2'b00));
      // flow control on VC0
      tbl.push_back(mk(1'b0, HEAD,     1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00));
      tbl.push_back(mk(1'b1, HEAD,     1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 2'b01));
      tbl.push_back(mk(1'b1, BODY,     1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00));
      tbl.push_back(mk(1'b1, BODY,     1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 2'b01));
      // protocol errors
      tbl.push_back(mk(1'b1, BODY,     1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 2'b10, 2'b01));
      tbl.push_back(mk(1'b1, HEAD,     1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 2'b10, 2'b01));
      tbl.push_back(mk(1'b0, HEAD,     1'b0, 1'b0, 1'b0, 2'b11, 2'b10, 1'b0, 1'b1, 2'b10, 2'b01));
      tbl.push_back(mk(1'b1, TAIL,     1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 2'b01));
      tbl.push_back(mk(1'b0, HEAD,     1'b0, 1'b0, 1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 2'b11, 2'b00));
      // grant on RESERVED, then interleaved packets on both VCs
      tbl.push_back(mk(1'b0, HEAD,     1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00));
      tbl.push_back(mk(1'b0, HEAD,     1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 2'b10, 2'b01));
      tbl.push_back(mk(1'b1, HEAD,     1'b0, 1'b1, 1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 2'b01));
      tbl.push_back(mk(1'b1, HEAD,     1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 2'b11));
      tbl.push_back(mk(1'b1, TAIL,     1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 2'b11));
      tbl.push_back(mk(1'b1, TAIL,     1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 2'b01));
      tbl.push_back(mk(1'b0, HEAD,     1'b0, 1'b0, 1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 2'b11, 2'b00));
      // release and grant on the same VC in one cycle
      tbl.push_back(mk(1'b0, HEAD,     1'b0, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00));
      tbl.push_back(mk(1'b1, HEADTAIL, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 2'b10));
      tbl.push_back(mk(1'b0, HEAD,     1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 1'b0, 1'b1, 2'b11, 2'b00));
      // tail and release on the same VC in one cycle
      tbl.push_back(mk(1'b0, HEAD,     1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00));
      tbl.push_back(mk(1'b1, HEAD,     1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 2'b01));
      tbl.push_back(mk(1'b1, TAIL,     1'b0, 1'b0, 1'b0, 2'b11, 2'b01, 1'b1, 1'b1, 2'b10, 2'b01));
      tbl.push_back(mk(1'b0, HEAD,     1'b0, 1'b0, 1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 2'b11, 2'b00));

      for (int i = 0; i < tbl.size(); i++) begin
         t = tbl[i];
         @(negedge clk);
         f.flit_label  = t.lb;
         f.vc_id       = t.vc;
         f.data        = 16'hA000 + 16'(i);
         flit_i        = f;
         valid_i       = t.v;
         va_grant_i    = t.g;
         va_grant_vc_i = t.gvc;
         on_off_i      = t.oo;
         vc_release_i  = t.rel;
         #1;
         check($sformatf("row%0d send_ok_o", i), 32'(send_ok_o), 32'(t.esok));
         if (t.ev) last_flit = f;
         e.ev  = t.ev;
         e.ee  = t.ee;
         e.eav = t.eav;
         e.ef  = last_flit;
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check($sformatf("row%0d valid_o", i), 32'(valid_o), 32'(e.ev));
         check($sformatf("row%0d err_o", i), 32'(err_o), 32'(e.ee));
         check($sformatf("row%0d vc_available_o", i), 32'(vc_available_o), 32'(e.eav));
         check($sformatf("row%0d flit_o", i), 32'(flit_o), 32'(e.ef));
      end

      // reset in the middle of a packet with a flit on the link
      @(negedge clk);
      idle_inputs();
      va_grant_i = 1'b1;
      va_grant_vc_i = 1'b0;
      @(negedge clk);
      idle_inputs();
      f.flit_label = HEAD;
      f.vc_id      = 1'b0;
      f.data       = 16'h5A5A;
      flit_i       = f;
      valid_i      = 1'b1;
      @(posedge clk);
      #1;
      check("pre-reset valid_o", 32'(valid_o), 32'd1);
      check("pre-reset flit_o", 32'(flit_o), 32'(f));
      check("pre-reset vc_available_o", 32'(vc_available_o), 32'b10);
      #2;
      rst = 1'b1;
      #1;
      check("async reset valid_o", 32'(valid_o), 32'd0);
      check("async reset vc_available_o", 32'(vc_available_o), 32'b11);
      check("async reset err_o", 32'(err_o), 32'd0);
      check("async reset send_ok_o", 32'(send_ok_o), 32'b00);
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      f.flit_label = BODY;
      flit_i       = f;
      valid_i      = 1'b1;
      @(posedge clk);
      #1;
      check("post-reset body valid_o", 32'(valid_o), 32'd0);
      check("post-reset body err_o", 32'(err_o), 32'd1);
      check("post-reset vc_available_o", 32'(vc_available_o), 32'b11);
      @(negedge clk);
      idle_inputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
